covox_sd_dac: RTL and testbench

COVOX_SD_DAC -- requirements
Module: covox_sd_dac

---
 rtl/covox_sd_dac.sv | 96 +++++++++
 tb/tb_covox_sd_dac.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/covox_sd_dac.sv
// Covox 8-bit port #FB sample latch feeding a first-order sigma-delta DAC (1-bit output).
// Optional COVOX_BEEPER_MIX_EN mixes the beeper and tape-out bits into the modulator input.
module covox_sd_dac (
  input  logic       cpu_clock,
  input  logic       reset,
  input  logic       covox,
  input  logic [7:0] d,
  input  logic       beeper,
  input  logic       tapeout,
  output logic       dac_out,
  output logic [7:0] sample,
  output logic       sample_stb
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_HOLD} state_t;

  state_t     r_state;
  logic       r_s_stb;
  logic [7:0] r_s_d;
  logic [7:0] r_temp;
  logic [7:0] r_sample;
  logic       r_sample_stb;
  logic [7:0] r_acc;
  logic       r_dac_out;

  logic [7:0] w_mix;
  logic [8:0] w_sum;

  // The strobe must be seen on two consecutive registered cycles before it commits,
  // so single-cycle decoder glitches never reach the sample register.
  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_s_stb      <= 1'b0;
      r_s_d        <= 8'h00;
      r_temp       <= 8'h00;
      r_sample     <= 8'h80;
      r_sample_stb <= 1'b0;
    end else begin
      r_s_stb      <= covox;
      r_s_d        <= d;
      r_sample_stb <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_s_stb) begin
            r_temp  <= r_s_d;
            r_state <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (r_s_stb) begin
            r_sample     <= r_temp;
            r_sample_stb <= 1'b1;
            r_state      <= ST_HOLD;
          end else begin
            r_temp  <= 8'h00;
            r_state <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (!r_s_stb) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef COVOX_BEEPER_MIX_EN
  // Worst case 127 + 96 + 32 = 255, so the sum never wraps.
  assign w_mix = {1'b0, r_sample[7:1]} + (beeper ? 8'd96 : 8'd0) + (tapeout ? 8'd32 : 8'd0);
`else
  logic w_unused_mix;
  assign w_unused_mix = beeper ^ tapeout;
  assign w_mix        = r_sample;
`endif

  assign w_sum = {1'b0, r_acc} + {1'b0, w_mix};

  // Carry-out of the accumulator is the output bit; density is mix/256 per 256 cycles.
  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      r_acc     <= 8'h00;
      r_dac_out <= 1'b0;
    end else begin
      r_acc     <= w_sum[7:0];
      r_dac_out <= w_sum[8];
    end
  end

  assign dac_out    = r_dac_out;
  assign sample     = r_sample;
  assign sample_stb = r_sample_stb;

endmodule

// File: tb/tb_covox_sd_dac.sv
// Directed bench for covox_sd_dac: hand sequences for strobe timing/reset corners,
// then a vector table of writes with sample, pulse count and bitstream density checks.
module tb_covox_sd_dac;

  logic       cpu_clock;
  logic       reset;
  logic       covox;
  logic [7:0] d;
  logic       beeper;
  logic       tapeout;
  logic       dac_out;
  logic [7:0] sample;
  logic       sample_stb;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;

  localparam int ST_IDLE = 0;
  localparam int ST_ARM  = 1;
  localparam int ST_HOLD = 2;

  typedef struct {
    logic [7:0] d;
    logic       bp;
    logic       tp;
    int         len;
    int         exp_pulses;
    logic [7:0] exp_sample;
    int         mix_off;
    int         mix_on;
  } vec_t;

  vec_t vecs[6];

  covox_sd_dac dut (
    .cpu_clock  (cpu_clock),
    .reset      (reset),
    .covox      (covox),
    .d          (d),
    .beeper     (beeper),
    .tapeout    (tapeout),
    .dac_out    (dac_out),
    .sample     (sample),
    .sample_stb (sample_stb)
  );

  initial begin
    cpu_clock = 1'b0;
    forever #5 cpu_clock = ~cpu_clock;
  end

  always @(negedge cpu_clock) begin
    if (sample_stb) pulse_cnt++;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge cpu_clock);
    @(negedge cpu_clock);
  endtask

  function automatic int st();
    return int'(dut.r_state);
  endfunction

  initial begin
    int p0;
    int ones;
    int exp_mix;

    vecs[0] = '{8'h3C, 1'b0, 1'b0, 4, 1, 8'h3C,  60,  30};
    vecs[1] = '{8'hFF, 1'b1, 1'b0, 1, 0, 8'h3C,  60, 126};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 2, 1, 8'h00,   0, 128};
    vecs[3] = '{8'hFF, 1'b1, 1'b0, 3, 1, 8'hFF, 255, 223};
    vecs[4] = '{8'h80, 1'b0, 1'b1, 2, 1, 8'h80, 128,  96};
    vecs[5] = '{8'h01, 1'b0, 1'b0, 1, 0, 8'h80, 128,  64};

    reset = 1'b0; covox = 1'b0; d = 8'h00; beeper = 1'b0; tapeout = 1'b0;
    #12;
    chk("rst_sample", int'(sample), 8'h80);
    chk("rst_stb", int'(sample_stb), 0);
    chk("rst_dac", int'(dac_out), 0);
    chk("rst_state", st(), ST_IDLE);

    // Idle after reset release: bitstream pattern of the reset sample.
    @(negedge cpu_clock);
    reset = 1'b1;
    p0 = pulse_cnt;
    for (int k = 1; k <= 8; k++) begin
      step();
`ifdef COVOX_BEEPER_MIX_EN
      chk($sformatf("idle_dac_%0d", k), int'(dac_out), (k % 4 == 0) ? 1 : 0);
`else
      chk($sformatf("idle_dac_%0d", k), int'(dac_out), (k % 2 == 0) ? 1 : 0);
`endif
    end
    chk("idle_no_pulse", pulse_cnt - p0, 0);
    chk("idle_sample", int'(sample), 8'h80);

    // Four-cycle strobe: single commit on the third edge.
    p0 = pulse_cnt;
    covox = 1'b1; d = 8'h3C;
    step();
    chk("w4_e1_stb", int'(sample_stb), 0);
    step();
    chk("w4_e2_stb", int'(sample_stb), 0);
    chk("w4_e2_state", st(), ST_ARM);
    step();
    chk("w4_e3_stb", int'(sample_stb), 1);
    chk("w4_e3_sample", int'(sample), 8'h3C);
    chk("w4_e3_state", st(), ST_HOLD);
    step();
    chk("w4_e4_stb", int'(sample_stb), 0);
    covox = 1'b0; d = 8'h00;
    step();
    chk("w4_e5_state", st(), ST_HOLD);
    step();
    chk("w4_e6_state", st(), ST_IDLE);
    step();
    chk("w4_pulses", pulse_cnt - p0, 1);

    // One-cycle glitch must not commit.
    p0 = pulse_cnt;
    covox = 1'b1; d = 8'hFF;
    step();
    covox = 1'b0; d = 8'h00;
    chk("g1_e1_state", st(), ST_IDLE);
    step();
    chk("g1_e2_state", st(), ST_ARM);
    step();
    chk("g1_e3_state", st(), ST_IDLE);
    step();
    chk("g1_pulses", pulse_cnt - p0, 0);
    chk("g1_sample", int'(sample), 8'h3C);

    // Back-to-back writes with a single low cycle between them.
    p0 = pulse_cnt;
    covox = 1'b1; d = 8'h10;
    repeat (2) step();
    covox = 1'b0;
    step();
    chk("b2b_first", int'(sample), 8'h10);
    covox = 1'b1; d = 8'hF0;
    repeat (2) step();
    covox = 1'b0; d = 8'h00;
    step();
    chk("b2b_stb_second", int'(sample_stb), 1);
    repeat (3) step();
    chk("b2b_pulses", pulse_cnt - p0, 2);
    chk("b2b_sample", int'(sample), 8'hF0);

    // Reset while in ARM with the strobe still high across release.
    p0 = pulse_cnt;
    covox = 1'b1; d = 8'hA5;
    repeat (2) step();
    chk("ra_state_arm", st(), ST_ARM);
    reset = 1'b0;
    #1;
    chk("ra_rst_state", st(), ST_IDLE);
    chk("ra_rst_sample", int'(sample), 8'h80);
    d = 8'h5A;
    repeat (2) step();
    chk("ra_no_commit", pulse_cnt - p0, 0);
    reset = 1'b1;
    step();
    chk("ra_e1_state", st(), ST_IDLE);
    chk("ra_e1_stb", int'(sample_stb), 0);
    step();
    chk("ra_e2_state", st(), ST_ARM);
    step();
    chk("ra_e3_stb", int'(sample_stb), 1);
    chk("ra_e3_sample", int'(sample), 8'h5A);
    covox = 1'b0; d = 8'h00;
    repeat (3) step();
    chk("ra_pulses", pulse_cnt - p0, 1);

    // Vector table: write, then check commit and modulator density.
    for (int i = 0; i < 6; i++) begin
      beeper = vecs[i].bp; tapeout = vecs[i].tp;
      p0 = pulse_cnt;
      covox = 1'b1; d = vecs[i].d;
      repeat (vecs[i].len) step();
      covox = 1'b0; d = 8'h00;
      repeat (4) step();
      chk($sformatf("v%0d_pulses", i), pulse_cnt - p0, vecs[i].exp_pulses);
      chk($sformatf("v%0d_sample", i), int'(sample), int'(vecs[i].exp_sample));
      chk($sformatf("v%0d_state", i), st(), ST_IDLE);
      ones = 0;
      for (int k = 0; k < 256; k++) begin
        step();
        if (dac_out) ones++;
      end
`ifdef COVOX_BEEPER_MIX_EN
      exp_mix = vecs[i].mix_on;
`else
      exp_mix = vecs[i].mix_off;
`endif
      chk($sformatf("v%0d_density", i), ones, exp_mix);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
